// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and sizing helper for the button debouncers
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW     = 2'd0,
    S_WAIT_HI = 2'd1,
    S_HIGH    = 2'd2,
    S_WAIT_LO = 2'd3
  } state_t;

  // Smallest width w with 2**w > cycles, i.e. the narrowest legal CNT_W.
  function automatic int cnt_width(input longint unsigned cycles);
    int w;
    w = 1;
    while (w < 63 && (64'd1 << w) <= cycles) w++;
    return w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one-bit synchroniser, stability counter and press/release FSM
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int CNT_W           = 20,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_CYCLES   = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic level,
  output logic press,
  output logic rel
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam bit               REP     = (REPEAT_EN != 0);

  logic             sa, sb;
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             level_nx, press_nx, rel_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      sa    <= 1'b0;
      sb    <= 1'b0;
      state <= S_LOW;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      sa    <= button;
      sb    <= sa;
      state <= state_nx;
      cnt   <= cnt_nx;
      level <= level_nx;
      press <= press_nx;
      rel   <= rel_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_LOW:     if (sb) state_nx = S_WAIT_HI;
      S_WAIT_HI: begin
        if (!sb)                 state_nx = S_LOW;
        else if (cnt == DB_LAST) state_nx = S_HIGH;
      end
      S_HIGH:    if (!sb) state_nx = S_WAIT_LO;
      S_WAIT_LO: begin
        if (sb)                  state_nx = S_HIGH;
        else if (cnt == DB_LAST) state_nx = S_LOW;
      end
      default:   state_nx = S_LOW;
    endcase
  end

  // Pulses default low so every accepted event is exactly one cycle wide.
  always_comb begin
    cnt_nx   = cnt;
    level_nx = level;
    press_nx = 1'b0;
    rel_nx   = 1'b0;
    case (state)
      S_LOW: begin
        if (sb) cnt_nx = '0;
      end
      S_WAIT_HI: begin
        if (sb) begin
          if (cnt == DB_LAST) begin
            level_nx = 1'b1;
            press_nx = 1'b1;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
      end
      S_HIGH: begin
        if (!sb) begin
          cnt_nx = '0;
        end else if (REP && cnt == RP_LAST) begin
          press_nx = 1'b1;
          cnt_nx   = '0;
        end else if (REP) begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_WAIT_LO: begin
        if (sb) begin
          cnt_nx = '0;
        end else if (cnt == DB_LAST) begin
          level_nx = 1'b0;
          rel_nx   = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        cnt_nx   = '0;
        level_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multi_debounce.sv
// rtl/multi_debounce.sv - NCH independent debounced button channels with optional auto-repeat
module multi_debounce
  import debounce_pkg::*;
#(
  parameter int NCH             = 4,
  parameter int CNT_W           = 20,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_CYCLES   = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] button,
  output logic [NCH-1:0] level,
  output logic [NCH-1:0] press,
  output logic [NCH-1:0] rel
);

  if (NCH < 1 || NCH > 32) begin : g_bad_nch
    $error("multi_debounce: NCH must be 1..32");
  end
  if (DEBOUNCE_CYCLES < 2 || CNT_W < cnt_width(longint'(DEBOUNCE_CYCLES))) begin : g_bad_db
    $error("multi_debounce: DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W");
  end
  if (REPEAT_EN != 0 &&
      (REPEAT_CYCLES < 2 || CNT_W < cnt_width(longint'(REPEAT_CYCLES)))) begin : g_bad_rep
    $error("multi_debounce: REPEAT_CYCLES must be >= 2 and fit in CNT_W");
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    debounce_channel #(
      .CNT_W          (CNT_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_EN      (REPEAT_EN),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .button(button[i]),
      .level (level[i]),
      .press (press[i]),
      .rel   (rel[i])
    );
  end

endmodule

// File: doc/multi_debounce.md
Name: multi_debounce

Overview:
- Parametrised, multi-channel successor to the single-button debouncer FSM.
- The debounce timer is internal, so no external timer handshake is needed.
- Each channel synchronises a raw button input, rejects bounces shorter than DEBOUNCE_CYCLES, and provides a clean level, a one-cycle press pulse and a one-cycle release pulse.
- An optional auto-repeat mode re-fires press while a button is held.
- Sits between the board pushbuttons and the control FSMs that consume single-cycle button events.

Parameters:
- NCH, 4: number of independent button channels (1..32).
- CNT_W, 20: width of each per-channel counter.
- DEBOUNCE_CYCLES, 500000: cycles the synchronised input must stay stable to be accepted. Must satisfy 2 <= DEBOUNCE_CYCLES < 2^CNT_W.
- REPEAT_EN, 0: 1 enables auto-repeat of press while held.
- REPEAT_CYCLES, 0: auto-repeat period in cycles. Must be >= 2 and < 2^CNT_W when REPEAT_EN=1; ignored otherwise.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- button  input  NCH  raw asynchronous button inputs, active high.
- level  output  NCH  debounced, registered button state.
- press  output  NCH  one-cycle pulse on accepted press, and on each auto-repeat.
- rel  output  NCH  one-cycle pulse on accepted release.

Interface decision: one clock; reset is synchronous and active-high (clk, rst).

Behaviour:
- Reset:
  - On any clk edge with rst=1: all sync flops, level, press and rel go to 0, every counter goes to 0, and every channel goes to S_LOW.
  - Reset mid-debounce or mid-hold emits no pulses.
- Synchroniser: 2-flop chain per channel; sb = second stage.
- Per-channel FSM (states S_LOW, S_WAIT_HI, S_HIGH, S_WAIT_LO), evaluated per edge:
  - S_LOW:
    - sb=1: go to S_WAIT_HI, cnt <= 0.
    - Otherwise stay.
  - S_WAIT_HI:
    - sb=0: go to S_LOW (glitch rejected, no pulse).
    - Else if cnt == DEBOUNCE_CYCLES-1: go to S_HIGH, level <= 1, press <= 1, cnt <= 0.
    - Else cnt <= cnt+1.
  - S_HIGH:
    - sb=0: go to S_WAIT_LO, cnt <= 0.
    - Else if REPEAT_EN and cnt == REPEAT_CYCLES-1: press <= 1, cnt <= 0.
    - Else if REPEAT_EN: cnt <= cnt+1.
  - S_WAIT_LO:
    - sb=1: return to S_HIGH, cnt <= 0, no pulse. The repeat phase restarts.
    - Else if cnt == DEBOUNCE_CYCLES-1: go to S_LOW, level <= 0, rel <= 1.
    - Else cnt <= cnt+1.
- Pulse width: press and rel default to 0 each cycle, so each pulse is exactly one cycle. press and rel are never high together on a channel.
- Latency: if button is held from sampling edge k onward, press and level are high after edge k+DEBOUNCE_CYCLES+2. Release is symmetric (rel after edge k+DEBOUNCE_CYCLES+2, counting from the falling sampling edge).
- Counter: never wraps. Compare-equal terminates every count.
- Independence: channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.
- Illegal state: any other encoding goes to S_LOW with outputs cleared on the next edge.
- Outputs are all registered. No combinational path from button to any output.

Decomposition:
- Package debounce_pkg:
  - 2-bit state encoding constants S_LOW, S_WAIT_HI, S_HIGH, S_WAIT_LO.
  - Helper function computing CNT_W from a cycle count.
- Sub-module debounce_channel: synchroniser, counter, FSM and the three outputs for one bit.
- multi_debounce is a generate loop of NCH debounce_channel instances, plus parameter-legality checks.

Test Plan (NCH=4, DEBOUNCE_CYCLES=4, REPEAT_EN=0 unless stated):
- Clean press: button[0] rises and is held 20 cycles -> press[0] high for exactly 1 cycle after edge k+6; level[0]=1 from the same edge; other channels stay 0.
- Bounce rejection: button[1] toggles 1,0,1,0 every 2 cycles, then settles at 0 -> no press[1], level[1] stays 0. Then held at 1 -> a single press[1] pulse 6 edges after the settling edge.
- Release with glitch: channel 2 in S_HIGH, button[2] low for 2 cycles, then high, then low for 10 -> no rel on the first dip; one rel[2] pulse 6 edges after the final fall; level[2] returns to 0.
- Auto-repeat (REPEAT_EN=1, REPEAT_CYCLES=8): hold button[3] for 40 cycles -> first press at edge k+6, then further pulses every 8 cycles (k+14, k+22, k+30, k+38); exactly one rel after release.
- Reset mid-operation: assert rst for 1 cycle while channel 0 is in S_WAIT_HI with cnt=2 -> all outputs 0 after that edge; no press follows unless the button is re-held for a full 6 edges after rst deasserts.
- Simultaneous channels: all four buttons rise on the same edge -> press = 4'b1111 for one cycle and level = 4'b1111 from the same edge.
